// File: rtl/pe_match_row.sv
// pe_match_row: one row of PAT_MAX character compare cells.
// A pattern of 1..PAT_MAX characters is loaded first. Each accepted text
// character then shifts into a window, and the whole window is compared
// against the pattern. One registered result is produced per full-window
// position, and a match count is reported at end of stream.
module pe_match_row #(
    parameter int                DWIDTH    = 8,
    parameter int                PAT_MAX   = 16,
    parameter int                POS_W     = 16,
    parameter int                WILD_EN   = 1,
    parameter logic [DWIDTH-1:0] WILD_CHAR = DWIDTH'(8'h3F),
    localparam int               LW        = $clog2(PAT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [LW-1:0]     pat_len,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_char,
    input  logic              in_last,
    output logic              cfg_err,
    output logic              out_valid,
    output logic              match,
    output logic [POS_W-1:0]  match_pos,
    output logic              done,
    output logic [POS_W-1:0]  match_count
);

    localparam int IW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [LW-1:0]      plen_r;
    logic [LW-1:0]      idx_r;
    logic [POS_W-1:0]   pos_r;
    logic [DWIDTH-1:0]  pat_r      [PAT_MAX];
    logic [DWIDTH-1:0]  win_r      [PAT_MAX];
    logic [DWIDTH-1:0]  win_next_s [PAT_MAX];
    logic               cell_s     [PAT_MAX];
    logic               all_match_s;
    logic               accept_s;
    logic               len_ok_s;
    logic               full_s;
    logic [POS_W-1:0]   pos_next_s;

    logic               cfg_err_r;
    logic               out_valid_r;
    logic               match_r;
    logic [POS_W-1:0]   match_pos_r;
    logic               done_r;
    logic [POS_W-1:0]   match_count_r;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        if (v == {POS_W{1'b1}}) begin
            return v;
        end else begin
            return v + POS_W'(1);
        end
    endfunction

    assign in_ready    = ((state_r == ST_LOAD) || (state_r == ST_RUN)) && !clear;
    assign accept_s    = in_valid && in_ready;
    assign len_ok_s    = (pat_len != LW'(0)) && (pat_len <= LW'(PAT_MAX));
    assign pos_next_s  = sat_inc(pos_r);
    assign full_s      = (pos_next_s >= POS_W'(plen_r));

    assign cfg_err     = cfg_err_r;
    assign out_valid   = out_valid_r;
    assign match       = match_r;
    assign match_pos   = match_pos_r;
    assign done        = done_r;
    assign match_count = match_count_r;

    // Next window (with the incoming char) and per-cell compare against the reversed pattern.
    always_comb begin
        all_match_s   = 1'b1;
        win_next_s[0] = in_char;
        for (int k = 1; k < PAT_MAX; k++) begin
            win_next_s[k] = win_r[k-1];
        end
        for (int k = 0; k < PAT_MAX; k++) begin
            cell_s[k] = 1'b1;
            if (LW'(k) < plen_r) begin
                if (win_next_s[k] == pat_r[IW'(plen_r - LW'(1) - LW'(k))]) begin
                    cell_s[k] = 1'b1;
                end else if ((WILD_EN == 1) &&
                             (pat_r[IW'(plen_r - LW'(1) - LW'(k))] == WILD_CHAR)) begin
                    cell_s[k] = 1'b1;
                end else begin
                    cell_s[k] = 1'b0;
                end
            end else begin
                cell_s[k] = 1'b1;
            end
            all_match_s = all_match_s & cell_s[k];
        end
    end

    // Control FSM, pattern/window storage, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            plen_r        <= LW'(0);
            idx_r         <= LW'(0);
            pos_r         <= POS_W'(0);
            cfg_err_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            match_r       <= 1'b0;
            match_pos_r   <= POS_W'(0);
            done_r        <= 1'b0;
            match_count_r <= POS_W'(0);
            for (int k = 0; k < PAT_MAX; k++) begin
                pat_r[k] <= DWIDTH'(0);
                win_r[k] <= DWIDTH'(0);
            end
        end else begin
            cfg_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            if (clear) begin
                // Abort: pattern and match_count survive, pending pulses are dropped.
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            if (len_ok_s) begin
                                plen_r  <= pat_len;
                                idx_r   <= LW'(0);
                                state_r <= ST_LOAD;
                            end else begin
                                cfg_err_r <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (accept_s) begin
                            pat_r[IW'(idx_r)] <= in_char;
                            if (idx_r == (plen_r - LW'(1))) begin
                                idx_r         <= LW'(0);
                                pos_r         <= POS_W'(0);
                                match_count_r <= POS_W'(0);
                                state_r       <= ST_RUN;
                            end else begin
                                idx_r <= idx_r + LW'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (accept_s) begin
                            win_r <= win_next_s;
                            pos_r <= pos_next_s;
                            if (full_s) begin
                                out_valid_r <= 1'b1;
                                match_r     <= all_match_s;
                                match_pos_r <= pos_next_s - POS_W'(plen_r);
                                if (all_match_s) begin
                                    match_count_r <= sat_inc(match_count_r);
                                end
                            end
                            if (in_last) begin
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_match_row.sv
// Directed self-checking bench for pe_match_row (default parameters).
module tb_pe_match_row;

    localparam int LW = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic [LW-1:0] pat_len = '0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic        in_last = 1'b0;
    logic        cfg_err;
    logic        out_valid;
    logic        match;
    logic [15:0] match_pos;
    logic        done;
    logic [15:0] match_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ov_pos_q[$];
    logic        ov_match_q[$];
    int          done_seen;
    logic [15:0] done_cnt;

    pe_match_row dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .pat_len    (pat_len),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_last    (in_last),
        .cfg_err    (cfg_err),
        .out_valid  (out_valid),
        .match      (match),
        .match_pos  (match_pos),
        .done       (done),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Record every result and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_pos_q.push_back(match_pos);
            ov_match_q.push_back(match);
        end
        if (done === 1'b1) begin
            done_seen = done_seen + 1;
            done_cnt  = match_count;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ov_pos_q.delete();
        ov_match_q.delete();
        done_seen = 0;
        done_cnt  = 16'hFFFF;
    endtask

    task automatic load(input string s);
        cfg_start = 1'b1;
        pat_len   = LW'(s.len());
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic stream(input string s, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_char  = s[i];
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        tick();
    endtask

    string full_pat;

    initial begin
        full_pat = "0123456789ABCDEF";
        clear_log();

        // Reset state
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_match_count", 32'(match_count), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Illegal pattern lengths
        cfg_start = 1'b1;
        pat_len   = LW'(0);
        tick();
        cfg_start = 1'b0;
        chk("len0_cfg_err", 32'(cfg_err), 32'd1);
        chk("len0_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("len0_err_pulse", 32'(cfg_err), 32'd0);
        chk("len0_idle", 32'(in_ready), 32'd0);
        cfg_start = 1'b1;
        pat_len   = LW'(17);
        tick();
        cfg_start = 1'b0;
        chk("len17_cfg_err", 32'(cfg_err), 32'd1);
        chk("len17_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("len17_err_pulse", 32'(cfg_err), 32'd0);

        // "abc" over "xabcabc"
        load("abc");
        clear_log();
        stream("xabcabc", 7);
        chk("abc_nres", 32'(ov_pos_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < ov_pos_q.size(); i++) begin
            chk("abc_pos", 32'(ov_pos_q[i]), 32'(i));
            chk("abc_match", 32'(ov_match_q[i]), (i == 1 || i == 4) ? 32'd1 : 32'd0);
        end
        chk("abc_done", 32'(done_seen), 32'd1);
        chk("abc_count", 32'(done_cnt), 32'd2);
        chk("abc_idle", 32'(in_ready), 32'd0);

        // Wildcard "a?c" over "abcaxc"
        load("a?c");
        clear_log();
        stream("abcaxc", 6);
        chk("wild_nres", 32'(ov_pos_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < ov_pos_q.size(); i++) begin
            chk("wild_pos", 32'(ov_pos_q[i]), 32'(i));
            chk("wild_match", 32'(ov_match_q[i]), (i == 0 || i == 3) ? 32'd1 : 32'd0);
        end
        chk("wild_count", 32'(done_cnt), 32'd2);

        // Full-length pattern, exact text
        load(full_pat);
        clear_log();
        stream(full_pat, 16);
        chk("full_nres", 32'(ov_pos_q.size()), 32'd1);
        if (ov_pos_q.size() > 0) begin
            chk("full_pos", 32'(ov_pos_q[0]), 32'd0);
            chk("full_match", 32'(ov_match_q[0]), 32'd1);
        end
        chk("full_count", 32'(done_cnt), 32'd1);

        // Full-length pattern, text one char short
        load(full_pat);
        clear_log();
        stream(full_pat, 15);
        chk("short_nres", 32'(ov_pos_q.size()), 32'd0);
        chk("short_done", 32'(done_seen), 32'd1);
        chk("short_count", 32'(done_cnt), 32'd0);

        // Backpressure: in_valid toggling, pattern "ab"
        load("ab");
        in_valid = 1'b1; in_char = "a"; tick();
        chk("bp_fill", 32'(out_valid), 32'd0);
        in_valid = 1'b0; tick();
        chk("bp_gap0", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_char = "b"; tick();
        chk("bp_ov1", 32'(out_valid), 32'd1);
        chk("bp_pos1", 32'(match_pos), 32'd0);
        chk("bp_m1", 32'(match), 32'd1);
        in_valid = 1'b0; tick();
        chk("bp_gap1", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_char = "a"; tick();
        chk("bp_ov2", 32'(out_valid), 32'd1);
        chk("bp_pos2", 32'(match_pos), 32'd1);
        chk("bp_m2", 32'(match), 32'd0);

        // Clear with a char on offer
        in_valid = 1'b1; in_char = "b"; clear = 1'b1;
        #1;
        chk("clr_not_ready", 32'(in_ready), 32'd0);
        tick();
        clear = 1'b0;
        chk("clr_no_ov", 32'(out_valid), 32'd0);
        chk("clr_idle", 32'(in_ready), 32'd0);
        chk("clr_count_hold", 32'(match_count), 32'd1);
        in_valid = 1'b0;

        // Async reset mid-RUN
        load("ab");
        in_valid = 1'b1; in_char = "x"; tick();
        in_char = "a"; tick();
        in_char = "b"; tick();
        chk("ar_pre_ov", 32'(out_valid), 32'd1);
        chk("ar_pre_count", 32'(match_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_match", 32'(match), 32'd0);
        chk("ar_match_pos", 32'(match_pos), 32'd0);
        chk("ar_count", 32'(match_count), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_idle", 32'(in_ready), 32'd0);
        chk("ar_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_match_row.md
Name: pe_match_row

Overview:
- Parametrised successor to the single-character compare PE: one row of PAT_MAX compare cells, a loadable pattern and a streaming text window.
- Loads a pattern of 1..PAT_MAX characters, then compares every accepted text character against the whole pattern.
- Reports a registered match result per window position, plus a match count at end of stream.
- Sits between the character stream source and the match collector in the string-matching datapath.

Parameters:
- DWIDTH, 8: character width in bits.
- PAT_MAX, 16: maximum pattern length, which is also the number of compare cells.
- POS_W, 16: width of the text position counter and the match counter.
- WILD_EN, 1: when 1, a pattern character equal to WILD_CHAR matches any text character.
- WILD_CHAR, 8'h3F: wildcard code (the '?' character).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_start  input  1  one-cycle pulse in IDLE; latches pat_len and enters LOAD.
- pat_len  input  LW=$clog2(PAT_MAX+1)  pattern length; sampled only with cfg_start.
- clear  input  1  synchronous abort to IDLE from any state.
- in_valid  input  1  in_char is valid.
- in_ready  output  1  block accepts in_char this cycle.
- in_char  input  DWIDTH  pattern character in LOAD, text character in RUN.
- in_last  input  1  marks the final text character; valid with in_valid in RUN only.
- cfg_err  output  1  one-cycle pulse when pat_len is illegal.
- out_valid  output  1  one-cycle pulse; match and match_pos are valid.
- match  output  1  window equals the pattern.
- match_pos  output  POS_W  text index of the first character of the compared window.
- done  output  1  one-cycle pulse at end of stream.
- match_count  output  POS_W  number of matches in the stream; valid with done, held afterwards.

Behaviour:
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - All outputs go to 0: in_ready, cfg_err, out_valid, match, match_pos, done, match_count.
  - Pattern registers, window registers and counters clear to 0.
- Handshake: a character is accepted when in_valid && in_ready.
  - in_ready = (state==LOAD || state==RUN) && !clear. It is combinational and does not depend on in_valid.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On cfg_start with 1 <= pat_len <= PAT_MAX: latch plen, clear the load index, go to LOAD.
  - On cfg_start with pat_len==0 or pat_len>PAT_MAX: cfg_err=1 for one cycle; stay in IDLE.
- LOAD:
  - Each accepted char is written to pat[idx], idx increments.
  - The character accepted when idx==plen-1 is written, then state goes to RUN; idx and pos clear to 0.
  - in_last is ignored in LOAD.
- RUN:
  - Each accepted char shifts into the window: win[0] takes the new char, win[k] takes win[k-1].
  - pos (accepted text count) increments and saturates at 2^POS_W-1.
  - Compare, using the window including the newly accepted char:
    - Cell k (0 <= k < plen) compares win[k] with pat[plen-1-k].
    - A cell is true if the characters are equal, or if WILD_EN=1 and the pattern char is WILD_CHAR.
    - Cells k >= plen are forced true.
  - Once the accepted count is >= plen:
    - The cycle after acceptance: out_valid=1, match = AND of all cells, match_pos = (count after acceptance) - plen.
    - If match=1, match_count increments, saturating at 2^POS_W-1.
  - Before the window is full, out_valid stays 0.
  - Latency from acceptance to out_valid is exactly 1 cycle. Back-to-back acceptance gives back-to-back out_valid.
  - Accepted char with in_last=1: its compare result is still produced in the next cycle, and the state goes to DONE.
- DONE:
  - Lasts one cycle: done=1, match_count is final.
  - Then IDLE. The pattern is retained, but a new cfg_start is required.
  - match_count holds until the next transition from LOAD to RUN, where it clears.
- clear:
  - Highest priority below reset. Next state is IDLE.
  - Any char offered in the same cycle is not accepted (in_ready=0).
  - Pending out_valid/done for that edge are suppressed.
  - The pattern is kept; match_count holds.
- Simultaneous cfg_start and clear in IDLE: clear wins and cfg_start is ignored.
- cfg_start outside IDLE is ignored.
- Mid-operation async reset: same as power-on reset; no partial output survives.
- Text stream shorter than plen: no out_valid; done still pulses with match_count=0.

Test Plan:
- Load "abc" (plen=3), stream "xabcabc" with in_last on the final 'c', in_valid held high:
  - out_valid pulses at match_pos 0..4.
  - match=1 only at pos 1 and 4.
  - done is asserted with match_count=2.
- Illegal pattern length:
  - cfg_start with pat_len=0 → cfg_err pulse, stays in IDLE, in_ready=0.
  - cfg_start with pat_len=PAT_MAX+1 → same response.
- WILD_EN=1, pattern "a?c", stream "abcaxc" → matches at pos 0 and 3; match_count=2.
- Full-length pattern: plen=PAT_MAX, text equal to the pattern.
  - Exactly one out_valid, at pos 0, with match=1.
  - Stream shorter by one char → no out_valid; done is asserted with match_count=0.
- Backpressure and abort:
  - in_valid toggling 1/0 in RUN → out_valid only follows accepted chars, 1 cycle later.
  - clear with in_valid=1 → char not accepted; IDLE next cycle.
- Async reset: assert reset=0 mid-RUN between clock edges → all outputs 0 immediately; state IDLE after release.
